// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and the pc/inst hand-off toward the IF/ID register.
interface ifu_fetch_if #(
   parameter int unsigned PC_WIDTH   = 64,
   parameter int unsigned INST_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [PC_WIDTH-1:0]   req_addr;
   logic                  rsp_valid;
   logic [INST_WIDTH-1:0] rsp_data;
   logic                  redirect_valid;
   logic [PC_WIDTH-1:0]   redirect_pc;
   logic                  out_valid;
   logic                  out_ready;
   logic [PC_WIDTH-1:0]   out_pc;
   logic [INST_WIDTH-1:0] out_inst;

   modport master (
      output req_valid, req_addr, out_valid, out_pc, out_inst,
      input  req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  req_valid, req_addr, out_valid, out_pc, out_inst,
      output req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one memory read in flight and
// holds the fetched pc/inst in a single-entry buffer until ID takes it.
module ifu_fetch #(
   parameter int unsigned         PC_WIDTH   = 64,
   parameter int unsigned         INST_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(64'h8000_0000)
) (
   input  logic       clk,
   input  logic       rst,
   ifu_fetch_if.master bus
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                state_r;
   state_t                nextState_s;
   logic [PC_WIDTH-1:0]   pc_r;
   logic [PC_WIDTH-1:0]   pcNext_s;
   logic                  outValid_r;
   logic                  outValidNext_s;
   logic [PC_WIDTH-1:0]   outPc_r;
   logic [PC_WIDTH-1:0]   outPcNext_s;
   logic [INST_WIDTH-1:0] outInst_r;
   logic [INST_WIDTH-1:0] outInstNext_s;
   logic                  reqValid_s;
   logic                  reqFire_s;
   logic                  rspTake_s;
   logic [PC_WIDTH-1:0]   redirPc_s;

   // Requests go out only when the buffer is empty, so a response never needs backpressure.
   assign reqValid_s = rst && (state_r == S_REQ) && !outValid_r;
   assign reqFire_s  = reqValid_s && bus.req_ready;
   assign rspTake_s  = (state_r == S_WAIT) && bus.rsp_valid;
   assign redirPc_s  = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};

   assign bus.req_valid = reqValid_s;
   assign bus.req_addr  = pc_r;
   assign bus.out_valid = outValid_r;
   assign bus.out_pc    = outPc_r;
   assign bus.out_inst  = outInst_r;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= S_REQ;
         pc_r       <= RESET_PC;
         outValid_r <= 1'b0;
         outPc_r    <= {PC_WIDTH{1'b0}};
         outInst_r  <= {INST_WIDTH{1'b0}};
      end else begin
         state_r    <= nextState_s;
         pc_r       <= pcNext_s;
         outValid_r <= outValidNext_s;
         outPc_r    <= outPcNext_s;
         outInst_r  <= outInstNext_s;
      end
   end

   // Next-state logic; a redirect turns any accepted-but-unanswered request into a drop.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         S_REQ: begin
            if (bus.redirect_valid) begin
               nextState_s = reqFire_s ? S_DROP : S_REQ;
            end else begin
               nextState_s = reqFire_s ? S_WAIT : S_REQ;
            end
         end
         S_WAIT: begin
            if (bus.rsp_valid) begin
               nextState_s = S_REQ;
            end else if (bus.redirect_valid) begin
               nextState_s = S_DROP;
            end else begin
               nextState_s = S_WAIT;
            end
         end
         S_DROP: begin
            if (bus.rsp_valid) begin
               nextState_s = S_REQ;
            end else begin
               nextState_s = S_DROP;
            end
         end
         default: begin
            nextState_s = S_REQ;
         end
      endcase
   end

   // Output/datapath next values; redirect wins over response capture and consume.
   always_comb begin
      pcNext_s       = pc_r;
      outValidNext_s = outValid_r;
      outPcNext_s    = outPc_r;
      outInstNext_s  = outInst_r;
      if (bus.redirect_valid) begin
         pcNext_s       = redirPc_s;
         outValidNext_s = 1'b0;
      end else if (rspTake_s) begin
         pcNext_s       = pc_r + PC_WIDTH'(3'd4);
         outValidNext_s = 1'b1;
         outPcNext_s    = pc_r;
         outInstNext_s  = bus.rsp_data;
      end else if (outValid_r && bus.out_ready) begin
         outValidNext_s = 1'b0;
      end else begin
         outValidNext_s = outValid_r;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a scoreboard of expected pc/inst pairs is filled
// as responses are driven and drained whenever ID consumes an output.
module tb_ifu_fetch;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } expEntry_t;

   logic      clk;
   logic      rst;
   int        nTests = 0;
   int        nFail  = 0;
   expEntry_t expQ[$];
   expEntry_t monEntry;

   ifu_fetch_if #(.PC_WIDTH(64), .INST_WIDTH(32)) bus ();

   ifu_fetch #(
      .PC_WIDTH  (64),
      .INST_WIDTH(32),
      .RESET_PC  (64'h8000_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReq();
      int n = 0;
      while (!bus.req_valid && n < 20) begin
         tick();
         n++;
      end
      if (!bus.req_valid) checkEq("reqTimeout", 64'd0, 64'd1);
   endtask

   // Wait for a request, check its address and accept it at the next edge.
   task automatic acceptReq(input logic [63:0] expAddr);
      waitReq();
      checkEq("reqAddr", bus.req_addr, expAddr);
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
   endtask

   // One-cycle response for the accepted request, expected to reach the buffer.
   task automatic respond(input logic [63:0] pc, input logic [31:0] data);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = data;
      expQ.push_back('{pc: pc, inst: data});
      tick();
      bus.rsp_valid = 1'b0;
      checkEq("outValid", 64'(bus.out_valid), 64'd1);
      checkEq("outPc", bus.out_pc, pc);
      checkEq("outInst", 64'(bus.out_inst), 64'(data));
   endtask

   task automatic redirect(input logic [63:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   // Scoreboard: every ID handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            checkEq("sbUnexpected", 64'd1, 64'd0);
         end else begin
            monEntry = expQ.pop_front();
            checkEq("sbPc", bus.out_pc, monEntry.pc);
            checkEq("sbInst", 64'(bus.out_inst), 64'(monEntry.inst));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                = 1'b0;
      bus.req_ready      = 1'b0;
      bus.rsp_valid      = 1'b0;
      bus.rsp_data       = 32'h0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'h0;
      bus.out_ready      = 1'b1;
      tick();
      tick();
      checkEq("rstOutValid", 64'(bus.out_valid), 64'd0);
      checkEq("rstOutPc", bus.out_pc, 64'h0);
      checkEq("rstOutInst", 64'(bus.out_inst), 64'h0);
      checkEq("rstReqValid", 64'(bus.req_valid), 64'd0);
      checkEq("rstReqAddr", bus.req_addr, 64'h8000_0000);
      rst = 1'b1;

      // Basic fetch with immediate consume.
      acceptReq(64'h8000_0000);
      respond(64'h8000_0000, 32'h0000_0013);
      checkEq("bubbleReq", 64'(bus.req_valid), 64'd0);
      tick();
      checkEq("nextReqValid", 64'(bus.req_valid), 64'd1);
      checkEq("nextReqAddr", bus.req_addr, 64'h8000_0004);

      // ID stall holds the buffer and blocks new requests.
      bus.out_ready = 1'b0;
      acceptReq(64'h8000_0004);
      respond(64'h8000_0004, 32'h0010_0093);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkEq("stallPc", bus.out_pc, 64'h8000_0004);
         checkEq("stallInst", 64'(bus.out_inst), 64'h0010_0093);
         checkEq("stallReq", 64'(bus.req_valid), 64'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      checkEq("consumeBubble", 64'(bus.req_valid), 64'd0);
      tick();
      checkEq("afterStallValid", 64'(bus.out_valid), 64'd0);
      checkEq("afterStallReq", 64'(bus.req_valid), 64'd1);
      checkEq("afterStallAddr", bus.req_addr, 64'h8000_0008);

      // Redirect while waiting: response two cycles later is discarded.
      acceptReq(64'h8000_0008);
      redirect(64'h8000_0102);
      checkEq("dropReq", 64'(bus.req_valid), 64'd0);
      tick();
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hDEAD_BEEF;
      tick();
      bus.rsp_valid = 1'b0;
      checkEq("dropOutValid", 64'(bus.out_valid), 64'd0);
      checkEq("dropReqValid", 64'(bus.req_valid), 64'd1);
      checkEq("dropReqAddr", bus.req_addr, 64'h8000_0100);

      // Redirect on the same edge as the response.
      acceptReq(64'h8000_0100);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hCAFE_F00D;
      redirect(64'h8000_0200);
      bus.rsp_valid = 1'b0;
      checkEq("sameEdgeValid", 64'(bus.out_valid), 64'd0);
      checkEq("sameEdgeAddr", bus.req_addr, 64'h8000_0200);

      // Redirect while out_valid && out_ready.
      acceptReq(64'h8000_0200);
      respond(64'h8000_0200, 32'h0020_0113);
      redirect(64'h8000_0300);
      checkEq("redirConsumeValid", 64'(bus.out_valid), 64'd0);
      checkEq("redirConsumeAddr", bus.req_addr, 64'h8000_0300);

      // Redirect in S_REQ without and with a same-edge handshake.
      redirect(64'h8000_0404);
      checkEq("reqRedirValid", 64'(bus.req_valid), 64'd1);
      checkEq("reqRedirAddr", bus.req_addr, 64'h8000_0404);
      bus.req_ready = 1'b1;
      redirect(64'h8000_0500);
      bus.req_ready = 1'b0;
      checkEq("fireRedirDrop", 64'(bus.req_valid), 64'd0);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h1234_5678;
      tick();
      bus.rsp_valid = 1'b0;
      checkEq("fireRedirOut", 64'(bus.out_valid), 64'd0);
      checkEq("fireRedirAddr", bus.req_addr, 64'h8000_0500);

      // Low bits of the target are cleared; PC wraps past the top.
      redirect(64'hFFFF_FFFF_FFFF_FFFE);
      checkEq("alignAddr", bus.req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      acceptReq(64'hFFFF_FFFF_FFFF_FFFC);
      respond(64'hFFFF_FFFF_FFFF_FFFC, 32'h0010_0073);
      tick();
      checkEq("wrapAddr", bus.req_addr, 64'h0);

      // Asynchronous reset while waiting; orphan response afterwards is ignored.
      acceptReq(64'h0);
      #2;
      rst = 1'b0;
      #1;
      checkEq("midRstOutValid", 64'(bus.out_valid), 64'd0);
      checkEq("midRstReqValid", 64'(bus.req_valid), 64'd0);
      checkEq("midRstAddr", bus.req_addr, 64'h8000_0000);
      tick();
      rst = 1'b1;
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hBAD0_BAD0;
      tick();
      bus.rsp_valid = 1'b0;
      checkEq("orphanOutValid", 64'(bus.out_valid), 64'd0);
      checkEq("orphanReqValid", 64'(bus.req_valid), 64'd1);
      checkEq("orphanAddr", bus.req_addr, 64'h8000_0000);
      acceptReq(64'h8000_0000);
      respond(64'h8000_0000, 32'h0000_0013);
      tick();
      tick();
      checkEq("sbDrained", 64'(expQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
